// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StHold = 3'd3,
    StErr  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned OPCODE_W         = 7;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: redirect load has priority over the sequential +4 step.
module instr_fetch_unit_pc_reg #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_en_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_en_i) begin
      pc_d = load_val_i;
    end else if (inc_en_i) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one word fetch at a time, holds the result for decode, handles redirects.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_target,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instruction,
  output logic [OPCODE_W-1:0] opcode,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                misalign_err
);

  fetch_state_e      state_q;
  logic              kill_q;
  logic              instr_valid_q;
  logic [31:0]       instruction_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              misalign_err_q;
  logic [ADDR_W-1:0] pc_q;

  logic active, redirect_ok, pc_load, pc_inc;

  always_comb begin
    active      = (state_q == StReq) || (state_q == StWait) || (state_q == StHold);
    redirect_ok = redirect_valid && (redirect_target[1:0] == 2'b00);
    pc_load     = active && redirect_ok;
    pc_inc      = (state_q == StWait) && imem_rsp_valid && !kill_q && !redirect_valid;
  end

  instr_fetch_unit_pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_en_i (pc_load),
    .load_val_i(redirect_target),
    .inc_en_i  (pc_inc),
    .pc_o      (pc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      kill_q         <= 1'b0;
      instr_valid_q  <= 1'b0;
      instruction_q  <= '0;
      instr_pc_q     <= '0;
      misalign_err_q <= 1'b0;
    end else if (active && redirect_valid) begin
      if (!redirect_ok) begin
        misalign_err_q <= 1'b1;
        instr_valid_q  <= 1'b0;
        kill_q         <= 1'b0;
        state_q        <= StErr;
      end else begin
        case (state_q)
          // A request accepted alongside the redirect is for the stale address.
          StReq: begin
            if (imem_req_ready) begin
              kill_q  <= 1'b1;
              state_q <= StWait;
            end
          end
          StWait: begin
            if (imem_rsp_valid) begin
              kill_q  <= 1'b0;
              state_q <= StReq;
            end else begin
              kill_q <= 1'b1;
            end
          end
          default: begin
            instr_valid_q <= 1'b0;
            state_q       <= StReq;
          end
        endcase
      end
    end else begin
      case (state_q)
        StIdle: state_q <= StReq;
        StReq: begin
          if (imem_req_ready) state_q <= StWait;
        end
        StWait: begin
          if (imem_rsp_valid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= StReq;
            end else begin
              instruction_q <= imem_rsp_data;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
              state_q       <= StHold;
            end
          end
        end
        StHold: begin
          if (instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= StReq;
          end
        end
        StErr:   state_q <= StErr;
        default: state_q <= StErr;
      endcase
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_addr      = pc_q;
  assign instr_valid    = instr_valid_q;
  assign instruction    = instruction_q;
  assign opcode         = instruction_q[OPCODE_W-1:0];
  assign instr_pc       = instr_pc_q;
  assign misalign_err   = misalign_err_q;

endmodule
